ex_mem_pipe: RTL and testbench

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_if.sv | 50 +++++
 rtl/ex_mem_pipe.sv | 134 +++++++++++++
 tb/tb_ex_mem_pipe.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// EX/MEM pipeline bus: EX-side instruction fields in, MEM-side registered fields out.
interface ex_mem_if;
  logic        EX_valid;
  logic [15:0] EX_alu_result;
  logic [2:0]  EX_alu_flags;
  logic        EX_set_flags;
  logic [2:0]  EX_cntrl_branch_op;
  logic        EX_cntrl_branch_instr;
  logic        EX_cntrl_pc_src;
  logic [15:0] EX_store_data;
  logic        EX_mem_read;
  logic        EX_mem_write;
  logic        EX_reg_write;
  logic [3:0]  EX_dst_reg;
  logic        EX_hlt_instr;

  logic        MEM_valid;
  logic [15:0] MEM_alu_result;
  logic [2:0]  MEM_alu_flags;
  logic [2:0]  MEM_cntrl_branch_op;
  logic        MEM_cntrl_branch_instr;
  logic        MEM_cntrl_pc_src;
  logic [15:0] MEM_store_data;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic        MEM_reg_write;
  logic [3:0]  MEM_dst_reg;

  // Driven by the EX stage.
  modport master (
    output EX_valid, EX_alu_result, EX_alu_flags, EX_set_flags,
           EX_cntrl_branch_op, EX_cntrl_branch_instr, EX_cntrl_pc_src,
           EX_store_data, EX_mem_read, EX_mem_write, EX_reg_write,
           EX_dst_reg, EX_hlt_instr,
    input  MEM_valid, MEM_alu_result, MEM_alu_flags, MEM_cntrl_branch_op,
           MEM_cntrl_branch_instr, MEM_cntrl_pc_src, MEM_store_data,
           MEM_mem_read, MEM_mem_write, MEM_reg_write, MEM_dst_reg
  );

  // Implemented by the pipeline register.
  modport slave (
    input  EX_valid, EX_alu_result, EX_alu_flags, EX_set_flags,
           EX_cntrl_branch_op, EX_cntrl_branch_instr, EX_cntrl_pc_src,
           EX_store_data, EX_mem_read, EX_mem_write, EX_reg_write,
           EX_dst_reg, EX_hlt_instr,
    output MEM_valid, MEM_alu_result, MEM_alu_flags, MEM_cntrl_branch_op,
           MEM_cntrl_branch_instr, MEM_cntrl_pc_src, MEM_store_data,
           MEM_mem_read, MEM_mem_write, MEM_reg_write, MEM_dst_reg
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall/flush handling, architectural flag
// register and a halt FSM that drains the pipe before asserting hlt.
module ex_mem_pipe (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      stall,
  input  logic      flush,
  ex_mem_if.slave   bus,
  output logic      hlt,
  output logic      draining
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [1:0] drain_cnt, drain_cnt_next;

  logic capture;   // registers may load new EX contents this cycle
  logic take;      // a valid instruction is accepted
  logic take_hlt;  // the accepted instruction is a halt
  logic bubble;    // MEM control fields are cleared this cycle

  assign capture  = !stall && !flush && (state == RUN);
  assign take     = capture && bus.EX_valid;
  assign take_hlt = take && bus.EX_hlt_instr;
  // Flush beats stall; otherwise an unstalled cycle that does not accept a
  // real (non-halt) instruction pushes a bubble into MEM.
  assign bubble   = flush || (!stall && !(take && !bus.EX_hlt_instr));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    unique case (state)
      RUN: begin
        if (take_hlt) begin
          state_next     = DRAIN;
          drain_cnt_next = 2'd2;
        end
      end
      DRAIN: begin
        // Drain counting ignores stall so the halt always completes.
        if (drain_cnt <= 2'd1) begin
          state_next     = HALTED;
          drain_cnt_next = 2'd0;
        end else begin
          drain_cnt_next = drain_cnt - 2'd1;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next     = RUN;
        drain_cnt_next = 2'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      hlt       <= 1'b0;
      draining  <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      hlt       <= (state_next == HALTED);
      draining  <= (state_next == DRAIN);
    end
  end

  // Payload fields: loaded on any capture, their value is don't-care in a bubble.
  // NOTE: the payload is reset too because MEM outputs must read 0 after reset;
  // this is a handful of flops, not a memory array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.MEM_alu_result      <= 16'h0000;
      bus.MEM_cntrl_branch_op <= 3'b000;
      bus.MEM_store_data      <= 16'h0000;
      bus.MEM_dst_reg         <= 4'd0;
    end else if (capture) begin
      bus.MEM_alu_result      <= bus.EX_alu_result;
      bus.MEM_cntrl_branch_op <= bus.EX_cntrl_branch_op;
      bus.MEM_store_data      <= bus.EX_store_data;
      bus.MEM_dst_reg         <= bus.EX_dst_reg;
    end
  end

  // Control fields: cleared by a bubble, loaded by an accepted instruction,
  // held while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.MEM_valid              <= 1'b0;
      bus.MEM_cntrl_branch_instr <= 1'b0;
      bus.MEM_cntrl_pc_src       <= 1'b0;
      bus.MEM_mem_read           <= 1'b0;
      bus.MEM_mem_write          <= 1'b0;
      bus.MEM_reg_write          <= 1'b0;
    end else if (bubble) begin
      bus.MEM_valid              <= 1'b0;
      bus.MEM_cntrl_branch_instr <= 1'b0;
      bus.MEM_cntrl_pc_src       <= 1'b0;
      bus.MEM_mem_read           <= 1'b0;
      bus.MEM_mem_write          <= 1'b0;
      bus.MEM_reg_write          <= 1'b0;
    end else if (capture) begin
      bus.MEM_valid              <= bus.EX_valid;
      bus.MEM_cntrl_branch_instr <= bus.EX_cntrl_branch_instr;
      bus.MEM_cntrl_pc_src       <= bus.EX_cntrl_pc_src;
      bus.MEM_mem_read           <= bus.EX_mem_read;
      bus.MEM_mem_write          <= bus.EX_mem_write;
      bus.MEM_reg_write          <= bus.EX_reg_write;
    end
  end

  // Architectural flags: only instructions that set flags update them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.MEM_alu_flags <= 3'b000;
    end else if (take && bus.EX_set_flags) begin
      bus.MEM_alu_flags <= bus.EX_alu_flags;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed testbench for ex_mem_pipe: pass-through, flags, stall/flush,
// stalled/squashed halt, drain sequence and reset out of HALTED.
module tb_ex_mem_pipe;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;
  logic hlt;
  logic draining;

  int checks;
  int failures;

  ex_mem_if bus ();

  ex_mem_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .flush    (flush),
    .bus      (bus),
    .hlt      (hlt),
    .draining (draining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clear_ex();
    bus.EX_valid              = 1'b0;
    bus.EX_alu_result         = 16'h0000;
    bus.EX_alu_flags          = 3'b000;
    bus.EX_set_flags          = 1'b0;
    bus.EX_cntrl_branch_op    = 3'b000;
    bus.EX_cntrl_branch_instr = 1'b0;
    bus.EX_cntrl_pc_src       = 1'b0;
    bus.EX_store_data         = 16'h0000;
    bus.EX_mem_read           = 1'b0;
    bus.EX_mem_write          = 1'b0;
    bus.EX_reg_write          = 1'b0;
    bus.EX_dst_reg            = 4'd0;
    bus.EX_hlt_instr          = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    stall    = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    clear_ex();

    // Reset with a busy-looking EX stage: nothing may leak through.
    bus.EX_valid      = 1'b1;
    bus.EX_alu_result = 16'hFFFF;
    bus.EX_alu_flags  = 3'b111;
    bus.EX_set_flags  = 1'b1;
    bus.EX_reg_write  = 1'b1;
    bus.EX_mem_write  = 1'b1;
    bus.EX_dst_reg    = 4'hF;
    tick();
    tick();
    check("rst_valid",  16'(bus.MEM_valid),      16'h0);
    check("rst_alu",    bus.MEM_alu_result,      16'h0);
    check("rst_flags",  16'(bus.MEM_alu_flags),  16'h0);
    check("rst_regwr",  16'(bus.MEM_reg_write),  16'h0);
    check("rst_memwr",  16'(bus.MEM_mem_write),  16'h0);
    check("rst_dst",    16'(bus.MEM_dst_reg),    16'h0);
    check("rst_hlt",    16'(hlt),                16'h0);
    check("rst_drain",  16'(draining),           16'h0);

    // Pass-through, one cycle latency.
    rst_n = 1'b1;
    clear_ex();
    bus.EX_valid      = 1'b1;
    bus.EX_alu_result = 16'hBEEF;
    bus.EX_dst_reg    = 4'd5;
    bus.EX_reg_write  = 1'b1;
    tick();
    check("pt_alu",    bus.MEM_alu_result,      16'hBEEF);
    check("pt_dst",    16'(bus.MEM_dst_reg),    16'h5);
    check("pt_regwr",  16'(bus.MEM_reg_write),  16'h1);
    check("pt_valid",  16'(bus.MEM_valid),      16'h1);

    // Flags: set 100, then a non-setting instruction carrying 011.
    clear_ex();
    bus.EX_valid     = 1'b1;
    bus.EX_alu_flags = 3'b100;
    bus.EX_set_flags = 1'b1;
    tick();
    check("flag_set",  16'(bus.MEM_alu_flags),  16'h4);
    bus.EX_alu_flags = 3'b011;
    bus.EX_set_flags = 1'b0;
    tick();
    check("flag_hold", 16'(bus.MEM_alu_flags),  16'h4);
    check("flag_valid", 16'(bus.MEM_valid),     16'h1);
    // An invalid instruction cannot touch flags and enters as a bubble.
    bus.EX_valid     = 1'b0;
    bus.EX_alu_flags = 3'b010;
    bus.EX_set_flags = 1'b1;
    bus.EX_reg_write = 1'b1;
    tick();
    check("flag_inv",  16'(bus.MEM_alu_flags),  16'h4);
    check("inv_valid", 16'(bus.MEM_valid),      16'h0);
    check("inv_regwr", 16'(bus.MEM_reg_write),  16'h0);

    // Capture a store, then stall for 3 cycles with a new instruction.
    clear_ex();
    bus.EX_valid      = 1'b1;
    bus.EX_alu_result = 16'hAAAA;
    bus.EX_store_data = 16'h5A5A;
    bus.EX_mem_write  = 1'b1;
    tick();
    check("st_memwr",  16'(bus.MEM_mem_write),  16'h1);
    check("st_data",   bus.MEM_store_data,      16'h5A5A);
    clear_ex();
    bus.EX_valid      = 1'b1;
    bus.EX_alu_result = 16'h1234;
    bus.EX_reg_write  = 1'b1;
    bus.EX_alu_flags  = 3'b001;
    bus.EX_set_flags  = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_alu",   bus.MEM_alu_result,      16'hAAAA);
      check("stall_memwr", 16'(bus.MEM_mem_write),  16'h1);
      check("stall_flags", 16'(bus.MEM_alu_flags),  16'h4);
    end
    // Flush wins over stall.
    flush = 1'b1;
    tick();
    check("flush_valid", 16'(bus.MEM_valid),      16'h0);
    check("flush_memwr", 16'(bus.MEM_mem_write),  16'h0);
    check("flush_flags", 16'(bus.MEM_alu_flags),  16'h4);
    stall = 1'b0;
    flush = 1'b0;
    tick();
    check("resume_alu",   bus.MEM_alu_result,      16'h1234);
    check("resume_valid", 16'(bus.MEM_valid),      16'h1);
    check("resume_flags", 16'(bus.MEM_alu_flags),  16'h1);

    // Squashed halt: ignored, pipe keeps running.
    clear_ex();
    bus.EX_valid     = 1'b1;
    bus.EX_hlt_instr = 1'b1;
    flush = 1'b1;
    tick();
    check("sq_drain", 16'(draining),          16'h0);
    check("sq_valid", 16'(bus.MEM_valid),     16'h0);
    flush = 1'b0;
    clear_ex();
    bus.EX_valid      = 1'b1;
    bus.EX_alu_result = 16'h1357;
    tick();
    tick();
    check("sq_hlt",   16'(hlt),               16'h0);
    check("sq_run",   bus.MEM_alu_result,     16'h1357);
    check("sq_rvld",  16'(bus.MEM_valid),     16'h1);

    // Stalled halt does not advance the FSM until captured.
    clear_ex();
    bus.EX_valid     = 1'b1;
    bus.EX_hlt_instr = 1'b1;
    stall = 1'b1;
    tick();
    tick();
    check("sth_drain", 16'(draining),         16'h0);
    stall = 1'b0;
    tick();  // halt captured at this edge (t)
    check("h_t1_drain", 16'(draining),        16'h1);
    check("h_t1_hlt",   16'(hlt),             16'h0);
    check("h_t1_valid", 16'(bus.MEM_valid),   16'h0);
    // A store arriving behind the halt must never be captured.
    clear_ex();
    bus.EX_valid      = 1'b1;
    bus.EX_mem_write  = 1'b1;
    bus.EX_alu_result = 16'h7777;
    tick();
    check("h_t2_drain", 16'(draining),           16'h1);
    check("h_t2_hlt",   16'(hlt),                16'h0);
    check("h_t2_memwr", 16'(bus.MEM_mem_write),  16'h0);
    tick();
    check("h_t3_hlt",   16'(hlt),                16'h1);
    check("h_t3_drain", 16'(draining),           16'h0);
    check("h_t3_memwr", 16'(bus.MEM_mem_write),  16'h0);
    tick();
    check("h_t4_hlt",   16'(hlt),                16'h1);
    check("h_t4_valid", 16'(bus.MEM_valid),      16'h0);

    // Reset out of HALTED, then normal operation on the first cycle.
    rst_n = 1'b0;
    tick();
    check("rh_hlt",   16'(hlt),                16'h0);
    check("rh_drain", 16'(draining),           16'h0);
    check("rh_valid", 16'(bus.MEM_valid),      16'h0);
    rst_n = 1'b1;
    clear_ex();
    bus.EX_valid      = 1'b1;
    bus.EX_alu_result = 16'hCAFE;
    bus.EX_dst_reg    = 4'd9;
    bus.EX_reg_write  = 1'b1;
    tick();
    check("post_valid", 16'(bus.MEM_valid),      16'h1);
    check("post_alu",   bus.MEM_alu_result,      16'hCAFE);
    check("post_dst",   16'(bus.MEM_dst_reg),    16'h9);
    check("post_hlt",   16'(hlt),                16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
